bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-requester arbiter that shares one single-port BRAM between the UART BRAM traffic controller (requester A) and a second on-chip client (requester B). It sits between both requesters and the BRAM port. It grants per-cycle access round-robin, lets a requester lock the port for bursts such as a full read dump or an erase sweep, bounds lock duration, and routes read-valid strobes back to the requester that issued each read.

## Interface
- DATA_WIDTH, 8, BRAM word width
- ADDR_WIDTH, 12, BRAM address width
- READ_LATENCY, 1, cycles from accepted read to valid from_BRAM (1 or 2)
- MAX_LOCK, 256, maximum owned cycles under lock while the other requester waits

- clk  in  1  clock, single domain
- rst  in  1  reset, asynchronous, active-high
- a_req / b_req  in  1  access request, held until granted
- a_lock / b_lock  in  1  keep ownership between accesses
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_WIDTH  access address
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_gnt / b_gnt  out  1  access accepted this cycle
- a_rvalid / b_rvalid  out  1  rdata valid for this requester
- rdata  out  DATA_WIDTH  from_BRAM passthrough
- en, write_enable  out  1  BRAM enable and write strobe
- addr  out  ADDR_WIDTH  BRAM address
- to_BRAM  out  DATA_WIDTH  BRAM write data
- from_BRAM  in  DATA_WIDTH  BRAM read data
- owner  out  2  00 idle, 01 A, 10 B

## Operation
- States: IDLE, OWN_A, OWN_B. The state is registered.
- IDLE:
  - Only one requester has req high: go to that requester's OWN state.
  - Both have req high: go to the OWN state selected by rr_ptr.
  - Neither: stay in IDLE.
- OWN_X, per cycle:
  - If x_req is high, the access is issued this cycle.
  - x_gnt = 1. en = 1.
  - write_enable = x_we. addr = x_addr. to_BRAM = x_wdata.
  - These outputs are combinational from the X inputs, gated by the state.
- Leaving OWN_X, evaluated each cycle:
  - x_lock = 0 and the other requester has req high: switch to OWN_other next cycle. This gives per-access alternation when both are unlocked.
  - x_lock = 0, x_req = 0, and the other requester has req low: go to IDLE.
  - x_lock = 1: stay, even if x_req = 0. Gaps are allowed.
  - Forced release: x_lock = 1, lock_cnt = MAX_LOCK-1, and the other requester has req high. Switch to the other requester next cycle. The locked requester then sees gnt low until it is re-granted.
- lock_cnt:
  - Counts owned cycles while lock is high and the other requester has req high.
  - Clears on every owner change.
  - Width is clog2(MAX_LOCK).
- rr_ptr: on each transition into OWN_X, rr_ptr is set to the other requester. Reset value is A.
- Read return:
  - Each accepted read (gnt high and we = 0) pushes a tag (valid, requester ID) into a READ_LATENCY-deep shift register.
  - At the output, the tag raises a_rvalid or b_rvalid for one cycle, aligned with from_BRAM.
  - Writes push no tag.
- The non-owner's gnt is always 0. The non-owner's inputs are ignored.

## Timing
- Reset values:
  - State IDLE, rr_ptr = A, lock_cnt = 0, tag pipe cleared.
  - Outputs en, write_enable, a_gnt, b_gnt, a_rvalid, b_rvalid = 0.
  - addr, to_BRAM = 0. owner = 00.
- Arbitration latency:
  - From IDLE, req at cycle n gives the first gnt at n+1.
  - Handover between owners has zero dead cycles: A's last access at n, B's first at n+1.
- rvalid is asserted exactly READ_LATENCY cycles after the accepting gnt.
- Reset mid-burst:
  - Pending rvalid tags are discarded. No rvalid is asserted after rst.
  - The requester must re-request.
- A lock dropped and req dropped in the same cycle releases next cycle.
- MAX_LOCK bounds the wait of the non-locking requester to MAX_LOCK+1 cycles.

## Structure
- Shared package bram_arb_pkg:
  - State encoding IDLE/OWN_A/OWN_B.
  - Requester ID constants REQ_A = 0, REQ_B = 1.
  - owner encoding.
- Sub-module bram_arb_rvalid_pipe: parameterised READ_LATENCY tag shift register with async reset. It outputs one-hot rvalid.
- Top-level contents: FSM, lock counter, combinational port mux.

## Test plan
- Reset: assert rst mid-cycle, with clk running or stopped. All outputs are 0 immediately and owner = 00. After release, everything stays idle while no req is high.
- Single write:
  - Stimulus: A requests write 0xAA to 0x005 at cycle n.
  - Response at n+1: a_gnt = 1, en = 1, write_enable = 1, addr = 0x005, to_BRAM = 0xAA. No rvalid follows.
- Contention, unlocked reads:
  - Stimulus: A and B both request from IDLE. A reads 0x010, B reads 0x020.
  - Response: grants alternate A, B, A, B starting n+1.
  - The BRAM model returns mem[addr]. a_rvalid and b_rvalid each pulse 1 cycle later with the correct data and no cross-tagging.
- Lock bound:
  - Setup: MAX_LOCK = 16. A is locked and reads 0x000 upward continuously. B requests write 0x55 to 0xFFF.
  - Response: B is granted exactly 16 A-cycles after B's req. A's gnt is low that cycle.
- Lock gap:
  - Stimulus: A holds lock with req low for 5 cycles while B requests.
  - Response: owner stays 01 and b_gnt stays low. On lock drop, B is granted next cycle.
- Reset during an outstanding read:
  - Setup: READ_LATENCY = 2. Assert rst one cycle after a read gnt.
  - Response: a_rvalid never asserts.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester BRAM port arbiter: FSM states,
// requester IDs, owner encoding and the read-return tag.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic logic [1:0] owner_of(input arb_state_t s);
        logic [1:0] o;
        case (s)
            OWN_A:   o = OWNER_A;
            OWN_B:   o = OWNER_B;
            default: o = OWNER_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bram_arb_rvalid_pipe.sv
// Read-return tag shift register: carries (valid, requester) alongside the
// BRAM read latency and presents a one-hot rvalid aligned with from_BRAM.
module bram_arb_rvalid_pipe
    import bram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid,
    input  logic push_id,
    output logic a_rvalid,
    output logic b_rvalid
);

    rd_tag_t [READ_LATENCY-1:0] pipe_q;
    rd_tag_t [READ_LATENCY-1:0] pipe_d;

    // Shift the tag pipe by one stage and insert the new tag at the head.
    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = push_valid;
        pipe_d[0].id    = push_id;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Tag pipe register; reset discards any reads still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign a_rvalid = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == REQ_A);
    assign b_rvalid = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == REQ_B);

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between requesters A and B: round-robin
// per-access arbitration, bounded port locking and tagged read return.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  b_req,
    input  logic                  a_lock,
    input  logic                  b_lock,
    input  logic                  a_we,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  en,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] to_BRAM,
    input  logic [DATA_WIDTH-1:0] from_BRAM,
    output logic [1:0]            owner
);

    localparam int CNT_W = ($clog2(MAX_LOCK) > 0) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_t       state_q, state_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_full_s;
    logic             push_valid_s;
    logic             push_id_s;

    assign lock_full_s = (lock_cnt_q == LOCK_LAST);

    // Next-state logic: a lock holds the port until it drops or the wait bound expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    state_d = (rr_q == REQ_A) ? OWN_A : OWN_B;
                end else if (a_req) begin
                    state_d = OWN_A;
                end else if (b_req) begin
                    state_d = OWN_B;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_A: begin
                if (a_lock) begin
                    state_d = (b_req && lock_full_s) ? OWN_B : OWN_A;
                end else if (b_req) begin
                    state_d = OWN_B;
                end else if (!a_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = OWN_A;
                end
            end
            OWN_B: begin
                if (b_lock) begin
                    state_d = (a_req && lock_full_s) ? OWN_A : OWN_B;
                end else if (a_req) begin
                    state_d = OWN_A;
                end else if (!b_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = OWN_B;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Round-robin pointer and lock counter; both react only to owner changes and contention.
    always_comb begin
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        if (state_d != state_q) begin
            lock_cnt_d = '0;
            if (state_d == OWN_A) begin
                rr_d = REQ_B;
            end else if (state_d == OWN_B) begin
                rr_d = REQ_A;
            end else begin
                rr_d = rr_q;
            end
        end else if ((state_q == OWN_A) && a_lock && b_req) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end else if ((state_q == OWN_B) && b_lock && a_req) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= REQ_A;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Port mux: only the owner reaches the BRAM, and only while it requests.
    always_comb begin
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        en           = 1'b0;
        write_enable = 1'b0;
        addr         = '0;
        to_BRAM      = '0;
        case (state_q)
            OWN_A: begin
                a_gnt        = a_req;
                en           = a_req;
                write_enable = a_req && a_we;
                addr         = a_addr;
                to_BRAM      = a_wdata;
            end
            OWN_B: begin
                b_gnt        = b_req;
                en           = b_req;
                write_enable = b_req && b_we;
                addr         = b_addr;
                to_BRAM      = b_wdata;
            end
            default: begin
                a_gnt = 1'b0;
                b_gnt = 1'b0;
            end
        endcase
    end

    assign push_valid_s = (a_gnt && !a_we) || (b_gnt && !b_we);
    assign push_id_s    = b_gnt ? REQ_B : REQ_A;

    bram_arb_rvalid_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rvalid_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid_s),
        .push_id    (push_id_s),
        .a_rvalid   (a_rvalid),
        .b_rvalid   (b_rvalid)
    );

    assign rdata = from_BRAM;
    assign owner = owner_of(state_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a behavioural BRAM model
// and a read-return scoreboard.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int RL = 2;
    localparam int ML = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    bit            clk_run = 1'b1;
    logic          a_req, b_req, a_lock, b_lock, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, en, write_enable;
    logic [DW-1:0] rdata, to_BRAM, from_BRAM;
    logic [AW-1:0] addr;
    logic [1:0]    owner;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic        id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    bram_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .MAX_LOCK(ML)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .b_req(b_req), .a_lock(a_lock), .b_lock(b_lock),
        .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
        .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .en(en), .write_enable(write_enable), .addr(addr),
        .to_BRAM(to_BRAM), .from_BRAM(from_BRAM), .owner(owner)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: unwritten words hold an address-derived pattern.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            mem_wr [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [RL];
    assign from_BRAM = rd_pipe[RL-1];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a[7:0] ^ 8'hA5) + {4'h0, a[11:8]};
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        return mem_wr[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (en && write_enable) begin
            mem[addr]    <= to_BRAM;
            mem_wr[addr] <= 1'b1;
        end
        rd_pipe[0] <= (en && !write_enable) ? exp_data(addr) : 8'h00;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        a_we = 1'b0; b_we = 1'b0; a_addr = '0; b_addr = '0;
        a_wdata = '0; b_wdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic rvalid_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                checks++;
                e = sbq.pop_front();
                $display("FAIL rvalid_missing id=%b due=%0d now=%0d required rvalid", e.id, e.due, cyc);
            end
            if (a_rvalid || b_rvalid) begin
                checks++;
                if (a_rvalid && b_rvalid) begin
                    $display("FAIL rvalid_onehot a=%b b=%b required one-hot", a_rvalid, b_rvalid);
                end else if (sbq.size() == 0) begin
                    $display("FAIL rvalid_unexpected a=%b b=%b cyc=%0d required none", a_rvalid, b_rvalid, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (e.due != cyc || e.id !== b_rvalid || e.data !== rdata)
                        $display("FAIL rvalid_match cyc=%0d id=%b data=%h required cyc=%0d id=%b data=%h",
                                 cyc, b_rvalid, rdata, e.due, e.id, e.data);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({en, write_enable, a_gnt, b_gnt, a_rvalid, b_rvalid, owner, addr, to_BRAM} !== '0)
            $display("FAIL reset_outputs en=%b we=%b gnt=%b%b rv=%b%b owner=%b addr=%h wd=%h required all 0",
                     en, write_enable, a_gnt, b_gnt, a_rvalid, b_rvalid, owner, addr, to_BRAM);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (owner !== 2'b00 || en !== 1'b0)
                $display("FAIL idle_after_reset owner=%b en=%b required 00/0", owner, en);
            else passes++;
        end
        // Reset mid-cycle with the clock running while A owns the port.
        tick();
        a_req = 1'b1; a_lock = 1'b1; a_addr = 12'h044;
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01 || a_gnt !== 1'b1)
            $display("FAIL reset_pre_own owner=%b a_gnt=%b required 01/1", owner, a_gnt);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({en, a_gnt, b_gnt, owner, addr, write_enable} !== '0)
            $display("FAIL reset_async_run en=%b a_gnt=%b owner=%b addr=%h required 0", en, a_gnt, owner, addr);
        else passes++;
        clear_inputs();
        tick();
        rst = 1'b0;
        // Reset with the clock stopped.
        a_req = 1'b1; a_addr = 12'h045;
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01 || a_gnt !== 1'b1)
            $display("FAIL reset_pre_stop owner=%b a_gnt=%b required 01/1", owner, a_gnt);
        else passes++;
        clk_run = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({en, a_gnt, b_gnt, owner, addr, a_rvalid, b_rvalid} !== '0)
            $display("FAIL reset_async_stopped en=%b a_gnt=%b owner=%b addr=%h required 0", en, a_gnt, owner, addr);
        else passes++;
        clear_inputs();
        #4 rst = 1'b0;
        #2 clk_run = 1'b1;
        tick();
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk);
            checks++;
            if (owner !== 2'b00 || en !== 1'b0 || a_rvalid !== 1'b0)
                $display("FAIL reset_stays_idle owner=%b en=%b a_rvalid=%b required 00/0/0", owner, en, a_rvalid);
            else passes++;
        end
        tick();
    endtask

    task automatic test_single_write();
        a_req = 1'b1; a_we = 1'b1; a_addr = 12'h005; a_wdata = 8'hAA;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b0 || en !== 1'b0)
            $display("FAIL write_latency a_gnt=%b en=%b required 0/0 in request cycle", a_gnt, en);
        else passes++;
        tick();
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, en, write_enable, addr, to_BRAM} !== {1'b1, 1'b0, 1'b1, 1'b1, 12'h005, 8'hAA})
            $display("FAIL single_write gnt=%b%b en=%b we=%b addr=%h wd=%h required 10/1/1/005/aa",
                     a_gnt, b_gnt, en, write_enable, addr, to_BRAM);
        else passes++;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b0 || en !== 1'b0)
            $display("FAIL write_release a_gnt=%b en=%b required 0/0", a_gnt, en);
        else passes++;
        repeat (RL + 2) @(negedge clk);
        checks++;
        if (owner !== 2'b00 || sbq.size() != 0)
            $display("FAIL write_done owner=%b pending=%0d required 00/0", owner, sbq.size());
        else passes++;
        tick();
    endtask

    task automatic test_contention();
        logic [AW-1:0] aa, ba;
        logic ea, eb;
        apply_reset();
        aa = 12'h010; ba = 12'h020;
        a_req = 1'b1; b_req = 1'b1; a_addr = aa; b_addr = ba;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin a_req = 1'b0; b_req = 1'b0; end
            ea = (k >= 1 && k <= 6 && (k % 2) == 1);
            eb = (k >= 1 && k <= 6 && (k % 2) == 0);
            @(negedge clk);
            checks++;
            if (a_gnt !== ea || b_gnt !== eb)
                $display("FAIL contention_gnt k=%0d gnt=%b%b required %b%b", k, a_gnt, b_gnt, ea, eb);
            else passes++;
            if (ea || eb) begin
                checks++;
                if (addr !== (ea ? aa : ba) || en !== 1'b1 || write_enable !== 1'b0)
                    $display("FAIL contention_port k=%0d addr=%h en=%b we=%b required %h/1/0",
                             k, addr, en, write_enable, ea ? aa : ba);
                else passes++;
                sbq.push_back('{due: cyc + RL, id: eb, data: exp_data(ea ? aa : ba)});
            end
            tick();
            if (ea) begin aa = aa + 12'h001; a_addr = aa; end
            if (eb) begin ba = ba + 12'h001; b_addr = ba; end
        end
        repeat (RL + 2) @(negedge clk);
        checks++;
        if (sbq.size() != 0 || owner !== 2'b00)
            $display("FAIL contention_drain pending=%0d owner=%b required 0/00", sbq.size(), owner);
        else passes++;
        tick();
    endtask

    task automatic test_lock_bound();
        logic [AW-1:0] aa;
        logic ea, eb;
        int breq_t;
        apply_reset();
        breq_t = 3;
        aa = 12'h000;
        a_req = 1'b1; a_lock = 1'b1; a_we = 1'b0; a_addr = aa;
        for (int t = 0; t < 24; t++) begin
            if (t == breq_t) begin b_req = 1'b1; b_we = 1'b1; b_addr = 12'hFFF; b_wdata = 8'h55; end
            if (t == breq_t + ML + 1) b_req = 1'b0;
            if (t == breq_t + ML + 3) begin a_req = 1'b0; a_lock = 1'b0; end
            eb = (t == breq_t + ML);
            ea = (t >= 1 && t < breq_t + ML + 3 && !eb);
            @(negedge clk);
            checks++;
            if (a_gnt !== ea || b_gnt !== eb)
                $display("FAIL lock_bound_gnt t=%0d gnt=%b%b required %b%b", t, a_gnt, b_gnt, ea, eb);
            else passes++;
            if (eb) begin
                checks++;
                if ({write_enable, addr, to_BRAM, owner} !== {1'b1, 12'hFFF, 8'h55, 2'b10})
                    $display("FAIL lock_bound_bwrite we=%b addr=%h wd=%h owner=%b required 1/fff/55/10",
                             write_enable, addr, to_BRAM, owner);
                else passes++;
            end
            if (ea) sbq.push_back('{due: cyc + RL, id: 1'b0, data: exp_data(aa)});
            tick();
            if (ea) begin aa = aa + 12'h001; a_addr = aa; end
        end
        repeat (RL + 1) @(negedge clk);
        checks++;
        if (sbq.size() != 0 || owner !== 2'b00)
            $display("FAIL lock_bound_drain pending=%0d owner=%b required 0/00", sbq.size(), owner);
        else passes++;
        tick();
    endtask

    task automatic test_lock_gap();
        logic ea, eb;
        logic [1:0] eo;
        apply_reset();
        for (int t = 0; t < 12; t++) begin
            if (t == 0) begin a_req = 1'b1; a_lock = 1'b1; a_we = 1'b0; a_addr = 12'h100; end
            if (t == 2) begin a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 12'hFFF; end
            if (t == 7) a_lock = 1'b0;
            if (t == 9) b_req = 1'b0;
            ea = (t == 1);
            eb = (t == 8);
            eo = (t == 0) ? 2'b00 : (t <= 7) ? 2'b01 : (t <= 9) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if (a_gnt !== ea || b_gnt !== eb || owner !== eo)
                $display("FAIL lock_gap t=%0d gnt=%b%b owner=%b required %b%b/%b", t, a_gnt, b_gnt, owner, ea, eb, eo);
            else passes++;
            if (ea) sbq.push_back('{due: cyc + RL, id: 1'b0, data: exp_data(12'h100)});
            if (eb) sbq.push_back('{due: cyc + RL, id: 1'b1, data: 8'h55});
            tick();
        end
        repeat (RL) @(negedge clk);
        checks++;
        if (sbq.size() != 0)
            $display("FAIL lock_gap_drain pending=%0d required 0", sbq.size());
        else passes++;
        tick();
    endtask

    task automatic test_reset_outstanding();
        apply_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h033;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1)
            $display("FAIL outstanding_gnt a_gnt=%b required 1", a_gnt);
        else passes++;
        tick();
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0)
                $display("FAIL outstanding_in_rst rvalid=%b%b required 00", a_rvalid, b_rvalid);
            else passes++;
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || owner !== 2'b00)
                $display("FAIL outstanding_after_rst rvalid=%b%b owner=%b required 00/00", a_rvalid, b_rvalid, owner);
            else passes++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        fork
            rvalid_monitor();
        join_none
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_single_write();
        test_contention();
        test_lock_bound();
        test_lock_gap();
        test_reset_outstanding();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
